// File: rtl/unary_window_acc.sv
// unary_window_acc: windowed bitstream-to-binary converter.
// After a start pulse, SKIP warm-up bits are discarded, then the ones in the
// next 2^WINLOG bits are counted and the count is held under valid/ready.
// Optional build macro: UNARY_WINDOW_ACC_BIPOLAR_EN (result = count - N/2).
module unary_window_acc #(
  parameter int WINLOG  = 8,
  parameter int SKIP    = 2,
  parameter int SKIPLOG = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WINLOG:0] result
);

  localparam int AW = WINLOG + 1;
  localparam logic [AW-1:0]      WIN_LAST  = AW'((2 ** WINLOG) - 1);
  localparam logic [AW-1:0]      HALF      = AW'(2 ** (WINLOG - 1));
  localparam logic [SKIPLOG-1:0] SKIP_LAST = SKIPLOG'(SKIP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACC,
    ST_HOLD
  } state_t;

  state_t               r_state;
  state_t               w_next;
  state_t               w_first;
  logic                 w_clr;
  logic                 w_load;
  logic [SKIPLOG-1:0]   r_skip_cnt;
  logic [AW-1:0]        r_win_cnt;
  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        r_result;
  logic [AW-1:0]        w_final;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; w_clr marks entry into a new conversion, w_load the last sample
  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_load  = 1'b0;
    w_first = (SKIP > 0) ? ST_SKIP : ST_ACC;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_first;
          w_clr  = 1'b1;
        end
      end
      ST_SKIP: begin
        if (r_skip_cnt == SKIP_LAST) w_next = ST_ACC;
      end
      ST_ACC: begin
        if (r_win_cnt == WIN_LAST) begin
          w_next = ST_HOLD;
          w_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (start) begin
            w_next = w_first;
            w_clr  = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Final count includes the sample taken on the last ACC cycle
  always_comb begin
`ifdef UNARY_WINDOW_ACC_BIPOLAR_EN
    w_final = r_acc + AW'(in) - HALF;
`else
    w_final = r_acc + AW'(in);
`endif
  end

  // Counters, accumulator and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
      r_win_cnt  <= '0;
      r_acc      <= '0;
      r_result   <= '0;
    end else begin
      if (w_clr) begin
        r_skip_cnt <= '0;
        r_win_cnt  <= '0;
        r_acc      <= '0;
      end else if (r_state == ST_SKIP) begin
        r_skip_cnt <= r_skip_cnt + SKIPLOG'(1);
      end else if (r_state == ST_ACC) begin
        r_win_cnt <= r_win_cnt + AW'(1);
        r_acc     <= r_acc + AW'(in);
      end
      if (w_load) r_result <= w_final;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign result    = r_result;

endmodule

// File: tb/tb_unary_window_acc.sv
// Self-checking bench for unary_window_acc (WINLOG=8, SKIP=2).
// Table-driven patterns, random windows against a counting model, and
// hand-written HOLD / back-to-back / mid-run reset sequences.
module tb_unary_window_acc;

  localparam int WINLOG = 8;
  localparam int SKIP   = 2;
  localparam int N      = 2 ** WINLOG;
  localparam int LEN    = SKIP + N;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [WINLOG:0] result;

  int n_checks;
  int n_fail;
  logic stim [0:LEN-1];

  unary_window_acc #(.WINLOG(WINLOG), .SKIP(SKIP), .SKIPLOG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in        (in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pattern;
    int    count;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int res_val();
`ifdef UNARY_WINDOW_ACC_BIPOLAR_EN
    return int'($signed(result));
`else
    return int'(result);
`endif
  endfunction

  function automatic int exp_res(input int cnt);
`ifdef UNARY_WINDOW_ACC_BIPOLAR_EN
    return cnt - N / 2;
`else
    return cnt;
`endif
  endfunction

  // Reference: ones among the N bits that follow the SKIP warm-up bits
  function automatic int model_count();
    int c = 0;
    for (int k = SKIP; k < LEN; k++) c += int'(stim[k]);
    return c;
  endfunction

  task automatic fill_pattern(input int p);
    for (int k = 0; k < LEN; k++) begin
      case (p)
        0: stim[k] = 1'b1;
        1: stim[k] = 1'b0;
        2: stim[k] = ((k - SKIP) % 2 == 0);
        3: stim[k] = (k < SKIP);
        4: stim[k] = (k != LEN - 1);
        5: stim[k] = ((k - SKIP) % 4 == 0);
        default: stim[k] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Starts a conversion (optionally together with a handshake in HOLD),
  // streams stim[] and checks latency and result at the end.
  task automatic run_conv(input string name, input int cnt, input bit b2b);
    bit early;
    early = 1'b0;
    start = 1'b1;
    out_ready = b2b;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    check({name, " busy after start"}, int'(busy), 1);
    if (b2b) check({name, " valid drops on handshake"}, int'(out_valid), 0);
    for (int k = 0; k < LEN; k++) begin
      if (out_valid) early = 1'b1;
      in = stim[k];
      step();
    end
    in = 1'b0;
    check({name, " valid early"}, int'(early), 0);
    check({name, " valid at SKIP+N+1"}, int'(out_valid), 1);
    check({name, " result"}, res_val(), exp_res(cnt));
  endtask

  task automatic ack(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " valid after ack"}, int'(out_valid), 0);
    check({name, " busy after ack"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vecs [6];
    int held;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in        = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{name: "all_ones",   pattern: 0, count: 256};
    vecs[1] = '{name: "all_zeros",  pattern: 1, count: 0};
    vecs[2] = '{name: "alternate",  pattern: 2, count: 128};
    vecs[3] = '{name: "skip_only",  pattern: 3, count: 0};
    vecs[4] = '{name: "last_zero",  pattern: 4, count: 255};
    vecs[5] = '{name: "every4th",   pattern: 5, count: 64};

    step();
    step();
    check("reset busy", int'(busy), 0);
    check("reset valid", int'(out_valid), 0);
    check("reset result", int'(result), 0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ready in idle ignored", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      fill_pattern(vecs[i].pattern);
      run_conv(vecs[i].name, vecs[i].count, 1'b0);
      ack(vecs[i].name);
    end

    for (int r = 0; r < 4; r++) begin
      fill_pattern(99);
      run_conv("random", model_count(), 1'b0);
      ack("random");
    end

    // HOLD with ready low: result stable, start ignored and not queued
    fill_pattern(99);
    run_conv("hold", model_count(), 1'b0);
    held = res_val();
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      step();
      start = 1'b0;
      check("hold result stable", res_val(), held);
      check("hold valid", int'(out_valid), 1);
      check("hold busy", int'(busy), 1);
    end
    ack("hold");
    step();
    check("hold start not queued", int'(busy), 0);

    // Back-to-back: start in the handshake cycle
    fill_pattern(99);
    run_conv("b2b first", model_count(), 1'b0);
    fill_pattern(99);
    run_conv("b2b second", model_count(), 1'b1);
    ack("b2b second");

    // Reset midway through ACC, then a clean conversion
    fill_pattern(0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < SKIP + 100; k++) begin
      in = stim[k];
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort valid", int'(out_valid), 0);
    check("abort result", int'(result), 0);
    step();
    rst_n = 1'b1;
    in = 1'b0;
    step();
    fill_pattern(99);
    run_conv("after abort", model_count(), 1'b0);
    ack("after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
